// File: rtl/tw_pkg.sv
// Shared constants, ROM write encodings and loader FSM states for the stage-0 twiddle path.
package tw_pkg;

   localparam int unsigned P_WIDTH         = 128;
   localparam int unsigned SEG1            = 64;
   localparam int unsigned SEG2            = 128;
   localparam int unsigned horizontal_DW   = SEG2 - SEG1;
   localparam int unsigned init_store_data = 4;
   localparam int unsigned IDX_W           = $clog2(init_store_data);

   localparam logic [1:0] ROM_W_IDLE = 2'd0;
   localparam logic [1:0] ROM_W_HI   = 2'd1;
   localparam logic [1:0] ROM_W_LO   = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FILL    = 3'd1,
      ST_SEND_HI = 3'd2,
      ST_SEND_LO = 3'd3,
      ST_DONE    = 3'd4
   } tw_state_e;

endpackage

// File: rtl/tw_stage_buf.sv
// Staging regfile for one twiddle row: one write port, one combinational half-word read port.
module tw_stage_buf
   import tw_pkg::*;
(
   input  logic                     CLK,
   input  logic                     wr_en,
   input  logic [IDX_W-1:0]         wr_idx,
   input  logic [P_WIDTH-1:0]       wr_data,
   input  logic [IDX_W-1:0]         rd_idx,
   input  logic                     rd_hi,
   output logic [horizontal_DW-1:0] rd_data
);

   logic [P_WIDTH-1:0] mem [init_store_data];

   // Capture accepted words; contents are always overwritten before being read.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = rd_hi ? mem[rd_idx][SEG2-1:SEG1] : mem[rd_idx][SEG1-1:0];

endmodule

// File: rtl/tw_row0_loader.sv
// Stage-0 twiddle row loader: buffers a row of 128-bit words, then writes all high
// halves followed by all low halves to the TW ROM in one gap-free burst.
module tw_row0_loader
   import tw_pkg::*;
(
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic [P_WIDTH-1:0]       in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic [1:0]               ROM1_w,
   output logic [horizontal_DW-1:0] horizontal_row0_in,
   output logic                     busy,
   output logic                     done
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(init_store_data - 1);

   tw_state_e                state, state_d;
   logic [IDX_W-1:0]         idx, idx_d;
   logic                     wr_en_c;
   logic                     rd_hi_c;
   logic [horizontal_DW-1:0] rd_data_c;

   logic [1:0]               rom_w_d;
   logic [horizontal_DW-1:0] row_data_d;
   logic                     in_ready_d;
   logic                     busy_d;
   logic                     done_d;

   tw_stage_buf u_buf (
      .CLK     (CLK),
      .wr_en   (wr_en_c),
      .wr_idx  (idx),
      .wr_data (in_data),
      .rd_idx  (idx_d),
      .rd_hi   (rd_hi_c),
      .rd_data (rd_data_c)
   );

   // State and shared entry index.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state <= ST_IDLE;
         idx   <= '0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
      end
   end

   // Next state / index; idx counts handshakes in FILL and ROM entries while sending.
   always_comb begin
      state_d = state;
      idx_d   = idx;
      wr_en_c = 1'b0;
      case (state)
         ST_IDLE: begin
            if (load_start) begin
               state_d = ST_FILL;
               idx_d   = '0;
            end
         end
         ST_FILL: begin
            if (in_valid && in_ready) begin
               wr_en_c = 1'b1;
               if (idx == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = ST_SEND_HI;
               end else begin
                  idx_d = idx + IDX_W'(1);
               end
            end
         end
         ST_SEND_HI: begin
            if (idx == IDX_LAST) begin
               idx_d   = '0;
               state_d = ST_SEND_LO;
            end else begin
               idx_d = idx + IDX_W'(1);
            end
         end
         ST_SEND_LO: begin
            if (idx == IDX_LAST) begin
               idx_d   = '0;
               state_d = ST_DONE;
            end else begin
               idx_d = idx + IDX_W'(1);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // Outputs are decoded from the upcoming state so the registers line up with it.
   always_comb begin
      rd_hi_c    = (state_d == ST_SEND_HI);
      rom_w_d    = ROM_W_IDLE;
      row_data_d = '0;
      in_ready_d = (state_d == ST_FILL);
      busy_d     = (state_d == ST_FILL) || (state_d == ST_SEND_HI) || (state_d == ST_SEND_LO);
      done_d     = (state_d == ST_DONE);
      if (state_d == ST_SEND_HI) begin
         rom_w_d    = ROM_W_HI;
         row_data_d = rd_data_c;
      end else if (state_d == ST_SEND_LO) begin
         rom_w_d    = ROM_W_LO;
         row_data_d = rd_data_c;
      end
   end

   // Output registers.
   always_ff @(posedge CLK) begin
      if (rst) begin
         ROM1_w             <= ROM_W_IDLE;
         horizontal_row0_in <= '0;
         in_ready           <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         ROM1_w             <= rom_w_d;
         horizontal_row0_in <= row_data_d;
         in_ready           <= in_ready_d;
         busy               <= busy_d;
         done               <= done_d;
      end
   end

endmodule

// File: tb/tb_tw_row0_loader.sv
// Self-checking bench for tw_row0_loader with a TW ROM consumer model.
module tb_tw_row0_loader;

   logic         CLK = 1'b0;
   logic         rst = 1'b0;
   logic         load_start = 1'b0;
   logic [127:0] in_data = '0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   ROM1_w;
   logic [63:0]  horizontal_row0_in;
   logic         busy;
   logic         done;

   int total = 0;
   int bad   = 0;

   logic [127:0] words [4];
   logic [1:0]   tr_w    [$];
   logic [63:0]  tr_d    [$];
   logic         tr_done [$];
   logic         tr_busy [$];
   logic         tr_rdy  [$];
   int           hs_idx;

   // TW ROM model: entry counter advances on every write, wraps after 4, clears on idle.
   logic [127:0] rom [4];
   int           rom_cnt = 0;

   always #5 CLK = ~CLK;

   tw_row0_loader dut (
      .CLK                (CLK),
      .rst                (rst),
      .load_start         (load_start),
      .in_data            (in_data),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .ROM1_w             (ROM1_w),
      .horizontal_row0_in (horizontal_row0_in),
      .busy               (busy),
      .done               (done)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
      tr_w.push_back(ROM1_w);
      tr_d.push_back(horizontal_row0_in);
      tr_done.push_back(done);
      tr_busy.push_back(busy);
      tr_rdy.push_back(in_ready);
      if (ROM1_w == 2'd1 || ROM1_w == 2'd2) begin
         if (ROM1_w == 2'd1) rom[rom_cnt][127:64] = horizontal_row0_in;
         else                rom[rom_cnt][63:0]   = horizontal_row0_in;
         rom_cnt = (rom_cnt == 3) ? 0 : rom_cnt + 1;
      end else begin
         rom_cnt = 0;
      end
   endtask

   task automatic rand_words();
      for (int k = 0; k < 4; k++) words[k] = {$urandom(), $urandom(), $urandom(), $urandom()};
   endtask

   // Runs one load of words[]; hs_idx = trace index of the cycle right after the last handshake.
   task automatic drive_load(input int gap, input bit rand_gap, input bit spam, input int rst_at);
      bit got;
      int j;
      int g;
      tr_w.delete(); tr_d.delete(); tr_done.delete(); tr_busy.delete(); tr_rdy.delete();
      load_start = 1'b1;
      in_valid   = 1'b0;
      tick();
      load_start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
      for (int k = 0; k < 4; k++) begin
         g = rand_gap ? int'($urandom_range(0, 3)) : gap;
         for (int c = 0; c < g; c++) begin
            in_valid = 1'b0;
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            if (spam) load_start = 1'($urandom_range(0, 1));
         end
         in_valid = 1'b1;
         in_data  = words[k];
         got = 1'b0;
         for (int t = 0; t < 20 && !got; t++) begin
            got = (in_ready === 1'b1);
            tick();
            if (spam) load_start = 1'($urandom_range(0, 1));
         end
         if (!got) begin
            total++; bad++;
            $display("FAIL handshake word %0d: in_ready=%b never 1 within 20 cycles", k, in_ready);
         end
      end
      hs_idx   = tr_w.size() - 1;
      in_valid = 1'b0;
      for (int c = 0; c < 14; c++) begin
         j = tr_w.size() - 1;
         if (spam && j < hs_idx + 8)  load_start = 1'($urandom_range(0, 1));
         else if (spam && j == hs_idx + 8) load_start = 1'b1;
         else load_start = 1'b0;
         rst = (rst_at >= 0 && j == hs_idx + rst_at);
         tick();
      end
      rst        = 1'b0;
      load_start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         load_start = 1'($urandom_range(0, 1));
         in_valid   = 1'($urandom_range(0, 1));
         in_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
         tick();
         total++;
         if ({ROM1_w, horizontal_row0_in, busy, done, in_ready} !== 69'd0) begin
            bad++;
            $display("FAIL reset cycle %0d: w=%0d d=%h busy=%b done=%b rdy=%b, want all 0",
                     c, ROM1_w, horizontal_row0_in, busy, done, in_ready);
         end
      end
      rst = 1'b0; load_start = 1'b0; in_valid = 1'b0;
      tick(); tick();
      total++;
      if ({ROM1_w, busy, done, in_ready} !== 5'd0) begin
         bad++;
         $display("FAIL reset idle: w=%0d busy=%b done=%b rdy=%b, want 0", ROM1_w, busy, done, in_ready);
      end
   endtask

   task automatic test_basic();
      logic [1:0]  ew;
      logic [63:0] ed;
      words[0] = 128'h0000000000000001_0000000000000001;
      words[1] = 128'hfffdffff00000003_5b11501d07d1bfa5;
      words[2] = 128'hfff7ffff00000001_ffeffffefffffff1;
      words[3] = 128'hffeffffefffffff1_52ca810d84ba33e7;
      drive_load(0, 1'b0, 1'b0, -1);
      total++;
      if (tr_busy[0] !== 1'b1 || tr_rdy[0] !== 1'b1) begin
         bad++;
         $display("FAIL basic fill entry: busy=%b rdy=%b, want 1 1", tr_busy[0], tr_rdy[0]);
      end
      for (int j = 0; j < 8; j++) begin
         ew = (j < 4) ? 2'd1 : 2'd2;
         ed = (j < 4) ? words[j][127:64] : words[j-4][63:0];
         total++;
         if (tr_w[hs_idx+j] !== ew || tr_d[hs_idx+j] !== ed) begin
            bad++;
            $display("FAIL basic write %0d: got w=%0d d=%h, want w=%0d d=%h",
                     j, tr_w[hs_idx+j], tr_d[hs_idx+j], ew, ed);
         end
      end
      total++;
      if (tr_rdy[hs_idx] !== 1'b0 || tr_w[hs_idx-1] !== 2'd0) begin
         bad++;
         $display("FAIL basic latency: rdy=%b prev_w=%0d, want 0 0", tr_rdy[hs_idx], tr_w[hs_idx-1]);
      end
      total++;
      if (tr_done[hs_idx+8] !== 1'b1 || tr_busy[hs_idx+8] !== 1'b0 || tr_w[hs_idx+8] !== 2'd0 ||
          tr_d[hs_idx+8] !== 64'd0 || tr_done[hs_idx+7] !== 1'b0 || tr_done[hs_idx+9] !== 1'b0) begin
         bad++;
         $display("FAIL basic done: done=%b busy=%b w=%0d d=%h, want 1 0 0 0 single pulse",
                  tr_done[hs_idx+8], tr_busy[hs_idx+8], tr_w[hs_idx+8], tr_d[hs_idx+8]);
      end
   endtask

   task automatic test_bubbly();
      logic [1:0]  ew;
      logic [63:0] ed;
      rand_words();
      drive_load(3, 1'b0, 1'b0, -1);
      total++;
      if (tr_w[hs_idx-1] !== 2'd0 || tr_w[hs_idx] !== 2'd1) begin
         bad++;
         $display("FAIL bubbly latency: w[hs-1]=%0d w[hs]=%0d, want 0 1", tr_w[hs_idx-1], tr_w[hs_idx]);
      end
      for (int j = 0; j < 8; j++) begin
         ew = (j < 4) ? 2'd1 : 2'd2;
         ed = (j < 4) ? words[j][127:64] : words[j-4][63:0];
         total++;
         if (tr_w[hs_idx+j] !== ew || tr_d[hs_idx+j] !== ed) begin
            bad++;
            $display("FAIL bubbly write %0d: got w=%0d d=%h, want w=%0d d=%h",
                     j, tr_w[hs_idx+j], tr_d[hs_idx+j], ew, ed);
         end
      end
      total++;
      if (tr_done[hs_idx+8] !== 1'b1) begin
         bad++;
         $display("FAIL bubbly done: got %b want 1", tr_done[hs_idx+8]);
      end
   endtask

   task automatic test_start_ignored();
      int nz;
      int nd;
      rand_words();
      drive_load(0, 1'b1, 1'b1, -1);
      nz = 0; nd = 0;
      for (int j = 0; j < tr_w.size(); j++) begin
         if (tr_w[j] != 2'd0) nz++;
         if (tr_done[j] == 1'b1) nd++;
      end
      total++;
      if (nz != 8 || nd != 1) begin
         bad++;
         $display("FAIL start_ignored: writes=%0d dones=%0d, want 8 1", nz, nd);
      end
      total++;
      if (tr_busy[tr_busy.size()-1] !== 1'b0 || tr_rdy[tr_rdy.size()-1] !== 1'b0) begin
         bad++;
         $display("FAIL start_ignored idle: busy=%b rdy=%b, want 0 0",
                  tr_busy[tr_busy.size()-1], tr_rdy[tr_rdy.size()-1]);
      end
      for (int k = 0; k < 4; k++) begin
         total++;
         if (rom[k] !== words[k]) begin
            bad++;
            $display("FAIL start_ignored rom %0d: got %h want %h", k, rom[k], words[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      int nd;
      rand_words();
      drive_load(0, 1'b0, 1'b0, 5);
      total++;
      if (tr_w[hs_idx+5] !== 2'd2 || tr_w[hs_idx+6] !== 2'd0 || tr_busy[hs_idx+6] !== 1'b0 ||
          tr_d[hs_idx+6] !== 64'd0) begin
         bad++;
         $display("FAIL reset_mid: w5=%0d w6=%0d busy6=%b d6=%h, want 2 0 0 0",
                  tr_w[hs_idx+5], tr_w[hs_idx+6], tr_busy[hs_idx+6], tr_d[hs_idx+6]);
      end
      nd = 0;
      for (int j = 0; j < tr_done.size(); j++) if (tr_done[j] == 1'b1) nd++;
      total++;
      if (nd != 0) begin
         bad++;
         $display("FAIL reset_mid done: got %0d pulses want 0", nd);
      end
   endtask

   task automatic test_e2e();
      logic [1:0]  ew;
      logic [63:0] ed;
      for (int r = 0; r < 3; r++) begin
         rand_words();
         drive_load(0, 1'b1, 1'b0, -1);
         for (int j = 0; j < 8; j++) begin
            ew = (j < 4) ? 2'd1 : 2'd2;
            ed = (j < 4) ? words[j][127:64] : words[j-4][63:0];
            total++;
            if (tr_w[hs_idx+j] !== ew || tr_d[hs_idx+j] !== ed) begin
               bad++;
               $display("FAIL e2e run %0d write %0d: got w=%0d d=%h, want w=%0d d=%h",
                        r, j, tr_w[hs_idx+j], tr_d[hs_idx+j], ew, ed);
            end
         end
         for (int k = 0; k < 4; k++) begin
            total++;
            if (rom[k] !== words[k]) begin
               bad++;
               $display("FAIL e2e run %0d rom %0d: got %h want %h", r, k, rom[k], words[k]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_bubbly();
      test_start_ignored();
      test_reset_mid();
      test_e2e();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
